pulse_train_gen: RTL and testbench

- Clocked generator that emits a programmed number of pulses on a single output line. It is the transmitting end for the edge-driven `counter` block: each emitted pulse ends in exactly one falling edge.
- Used to drive `counter` (and other negedge-sampled consumers) with a known, repeatable edge count for self-test and stimulus.
- A host loads a count and high/low phase widths, issues start, and gets busy/done status plus a live remaining-pulse count.

---
 rtl/pulse_train_gen_pkg.sv | 14 +
 rtl/pulse_train_gen_if.sv | 28 ++
 rtl/pulse_train_gen_phase_timer.sv | 25 ++
 rtl/pulse_train_gen.sv | 86 ++++++++
 tb/tb_pulse_train_gen.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pulse_train_gen_pkg.sv
// pulse_train_gen_pkg: shared state encoding and default widths for the pulse train generator.
//   DEF_WIDTH  - default width of pulse count / remaining count
//   DEF_TWIDTH - default width of the high/low phase cycle counts
//   state_t    - FSM states IDLE/HIGH/LOW/FINISH
package pulse_train_gen_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_TWIDTH = 8;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: host-side bundle of the pulse train generator.
//   master (host):      drives start, abort, pulse_count, high_cycles, low_cycles;
//                       observes pulse_out, busy, done, remaining
//   slave (generator):  the opposite directions
interface pulse_train_gen_if
    import pulse_train_gen_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TWIDTH = DEF_TWIDTH
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  pulse_count;
    logic [TWIDTH-1:0] high_cycles;
    logic [TWIDTH-1:0] low_cycles;
    logic              pulse_out;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  remaining;
    modport master (
        output start, abort, pulse_count, high_cycles, low_cycles,
        input  pulse_out, busy, done, remaining
    );
    modport slave (
        input  start, abort, pulse_count, high_cycles, low_cycles,
        output pulse_out, busy, done, remaining
    );
endinterface

// File: rtl/pulse_train_gen_phase_timer.sv
// pulse_train_gen_phase_timer: loadable down-counter timing one high or low phase.
//   clk, reset (async, active-low)
//   load  - load value on this edge (takes priority over counting)
//   value - cycles left after the load edge, i.e. phase length minus one
//   zero  - counter is at zero: current cycle is the last of the phase
module pulse_train_gen_phase_timer #(
    parameter int TWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TWIDTH-1:0] value,
    output logic              zero
);
    logic [TWIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmed number of pulses, each H cycles high then L cycles low.
//   clk   - system clock, all state on posedge
//   reset - asynchronous, active-low
//   bus   - slave side of pulse_train_gen_if: start/abort/pulse_count/high_cycles/low_cycles in,
//           pulse_out/busy/done/remaining out (all outputs registered)
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TWIDTH = DEF_TWIDTH
) (
    input  logic            clk,
    input  logic            reset,
    pulse_train_gen_if.slave bus
);
    state_t            state, state_nx;
    logic [TWIDTH-1:0] h_len, l_len, h_in, l_in, t_val;
    logic [WIDTH-1:0]  rem, rem_nx;
    logic              accept, t_load, t_zero;
    logic              pulse_q, busy_q, done_q;
    logic              pulse_nx, busy_nx, done_nx;

    assign accept = bus.start && !bus.abort;
    assign h_in   = (bus.high_cycles == '0) ? TWIDTH'(1) : bus.high_cycles;
    assign l_in   = (bus.low_cycles == '0) ? TWIDTH'(1) : bus.low_cycles;

    // Every phase entry is a change of state into HIGH or LOW; the timer is
    // loaded with length-1 so its zero flag marks the last cycle of the phase.
    assign t_load = (state_nx != state) && (state_nx == HIGH || state_nx == LOW);
    assign t_val  = (state_nx == HIGH) ? ((state == IDLE) ? h_in : h_len) - 1'b1 : l_len - 1'b1;

    pulse_train_gen_phase_timer #(.TWIDTH(TWIDTH)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .value (t_val),
        .zero  (t_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            h_len   <= '0;
            l_len   <= '0;
            rem     <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            rem     <= rem_nx;
            pulse_q <= pulse_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            if (state == IDLE && accept) begin
                h_len <= h_in;
                l_len <= l_in;
            end
        end
    end

    // abort forces IDLE from any state; in IDLE it also blocks start.
    always_comb begin
        state_nx = bus.abort       ? IDLE :
                   (state == IDLE) ? (accept ? ((bus.pulse_count == '0) ? FINISH : HIGH) : IDLE) :
                   (state == HIGH) ? (t_zero ? LOW : HIGH) :
                   (state == LOW)  ? (t_zero ? ((rem != '0) ? HIGH : FINISH) : LOW) :
                   IDLE;
    end

    // Outputs are registered from the next state, so they change on the same
    // edge as the state. Leaving HIGH (normally or by abort) completes a pulse.
    always_comb begin
        pulse_nx = (state_nx == HIGH);
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state == FINISH) && !bus.abort;
        rem_nx   = (state == IDLE && accept) ? bus.pulse_count :
                   (state == HIGH && (t_zero || bus.abort) && rem != '0) ? rem - 1'b1 :
                   rem;
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = rem;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed and randomized trains checked cycle by cycle against an arithmetic model.
module tb_pulse_train_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   edges = 0;

    always #5 clk = ~clk;

    pulse_train_gen_if #(.WIDTH(16), .TWIDTH(8)) bus ();

    pulse_train_gen #(.WIDTH(16), .TWIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // stands in for the negedge-sampled consumer
    always @(negedge bus.pulse_out) edges++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle k counts from the accepted start edge (k=1 is the first cycle after it).
    // Pulse j (0-based) is high in cycles j*P+1..j*P+H and low for the next L cycles.
    function automatic logic base_pulse(int n, int he, int le, int k);
        int p = he + le;
        return (k >= 1 && k <= n * p && ((k - 1) % p) < he);
    endfunction

    function automatic int base_rem(int n, int he, int le, int k);
        int p = he + le;
        if (k > n * p || k < 1) return 0;
        return n - ((k - 1) / p + ((((k - 1) % p) >= he) ? 1 : 0));
    endfunction

    task automatic model(input int n, input int he, input int le, input int ka, input int k,
                         output logic p, output logic b, output logic d, output int r);
        int bl = n * (he + le);
        if (ka != 0 && k > ka) begin
            p = 1'b0;
            b = 1'b0;
            d = 1'b0;
            r = base_rem(n, he, le, ka) - (base_pulse(n, he, le, ka) ? 1 : 0);
        end else begin
            p = base_pulse(n, he, le, k);
            b = (k >= 1 && k <= bl + 1);
            d = (k == bl + 2);
            r = base_rem(n, he, le, k);
        end
    endtask

    // ka = cycle in which abort is held high (0 = no abort)
    task automatic run_train(input int n, input int h, input int l, input int ka);
        int   he, le, bl, last, e0, r;
        logic p, b, d;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        bl = n * (he + le);
        last = (ka != 0) ? ka : bl + 2;
        e0 = edges;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.pulse_count = 16'(n);
        bus.high_cycles = 8'(h);
        bus.low_cycles = 8'(l);
        @(negedge clk);
        r = 0;
        for (int k = 1; k <= last + 2; k++) begin
            model(n, he, le, ka, k, p, b, d, r);
            check("pulse_out", 32'(bus.pulse_out), 32'(p));
            check("busy", 32'(bus.busy), 32'(b));
            check("done", 32'(bus.done), 32'(d));
            check("remaining", 32'(bus.remaining), 32'(r));
            bus.pulse_count = 16'($urandom);
            bus.high_cycles = 8'($urandom);
            bus.low_cycles = 8'($urandom);
            bus.abort = (k == ka);
            bus.start = (k <= ((ka != 0) ? ka : bl + 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("edge_count", 32'(edges - e0), 32'(n - r));
    endtask

    initial begin
        int n, h, l, ka, he, le;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pulse_count = '0;
        bus.high_cycles = '0;
        bus.low_cycles = '0;
        @(negedge clk);
        check("reset_pulse_out", 32'(bus.pulse_out), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_remaining", 32'(bus.remaining), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        run_train(5, 2, 3, 0);
        run_train(0, 3, 2, 0);
        run_train(3, 0, 0, 0);
        run_train(10, 3, 2, 17);
        // start together with abort in IDLE is ignored; remaining keeps 6
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.pulse_count = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", 32'(bus.busy), 32'd0);
        check("start_abort_pulse", 32'(bus.pulse_out), 32'd0);
        check("start_abort_remaining", 32'(bus.remaining), 32'd6);
        @(negedge clk);
        check("start_abort_busy2", 32'(bus.busy), 32'd0);
        // asynchronous reset in the middle of a high phase
        bus.start = 1'b1;
        bus.pulse_count = 16'd5;
        bus.high_cycles = 8'd4;
        bus.low_cycles = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_reset_pulse", 32'(bus.pulse_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_pulse", 32'(bus.pulse_out), 32'd0);
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        check("async_reset_remaining", 32'(bus.remaining), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(bus.busy), 32'd0);
        run_train(2, 1, 2, 0);
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 6);
            h = $urandom_range(0, 4);
            l = $urandom_range(0, 4);
            he = (h == 0) ? 1 : h;
            le = (l == 0) ? 1 : l;
            ka = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * (he + le) + 1) : 0;
            run_train(n, h, l, ka);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
